// File: rtl/systolic_tile.sv
// Output-stationary systolic MAC tile: skewed W/A operand injection, job FSM
// (load / flush / drain) and row-serial readout of the ROWS x COLS result block.
module systolic_tile #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int DW   = 8,
  parameter int AW   = 32,
  parameter int KW   = 16,
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [KW-1:0]        k_len,
  output logic                 busy,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ROWS*DW-1:0]   in_w,
  input  logic [COLS*DW-1:0]   in_a,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [COLS*AW-1:0]   out_data,
  output logic [RW-1:0]        out_row,
  output logic                 out_last,
  output logic                 done
);
  // state | meaning
  // IDLE  | waiting for start; accs hold the previous job's results
  // LOAD  | accepting operand vectors, one step per in_valid beat
  // FLUSH | injecting zero operands until the skewed wavefront leaves the array
  // DRAIN | presenting result rows 0..ROWS-1 on out_data
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DRAIN} state_t;

  localparam int FLUSH_N = ROWS + COLS - 2;

  state_t               state;
  logic [KW-1:0]        cnt;
  logic                 step;
  logic                 clr;
  logic signed [DW-1:0] w_src  [ROWS];
  logic signed [DW-1:0] w_inj  [ROWS];
  logic signed [DW-1:0] a_src  [COLS];
  logic signed [DW-1:0] a_inj  [COLS];
  logic signed [DW-1:0] w_pe   [ROWS][COLS];
  logic signed [DW-1:0] a_pe   [ROWS][COLS];
  logic signed [DW-1:0] w_left [ROWS][COLS];
  logic signed [DW-1:0] a_top  [ROWS][COLS];
  logic signed [2*DW-1:0] prod [ROWS][COLS];
  logic [AW-1:0]        acc    [ROWS][COLS];

  assign step = ((state == S_LOAD) && in_valid) || (state == S_FLUSH);
  assign clr  = (state == S_IDLE) && start;

  // Outside LOAD the skew chains are fed zeros so FLUSH pushes bubbles through.
  always_comb begin
    for (int i = 0; i < ROWS; i++) w_src[i] = (state == S_LOAD) ? in_w[DW*i +: DW] : '0;
    for (int j = 0; j < COLS; j++) a_src[j] = (state == S_LOAD) ? in_a[DW*j +: DW] : '0;
  end

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_wskew
    if (gi == 0) begin : g_direct
      assign w_inj[gi] = w_src[gi];
    end else begin : g_sr
      logic signed [DW-1:0] sr [gi];
      always_ff @(posedge clk) begin
        if (rst || clr) begin
          sr <= '{default: '0};
        end else if (step) begin
          sr[0] <= w_src[gi];
          for (int d = 1; d < gi; d++) sr[d] <= sr[d-1];
        end
      end
      assign w_inj[gi] = sr[gi-1];
    end
  end

  for (genvar gj = 0; gj < COLS; gj++) begin : g_askew
    if (gj == 0) begin : g_direct
      assign a_inj[gj] = a_src[gj];
    end else begin : g_sr
      logic signed [DW-1:0] sr [gj];
      always_ff @(posedge clk) begin
        if (rst || clr) begin
          sr <= '{default: '0};
        end else if (step) begin
          sr[0] <= a_src[gj];
          for (int d = 1; d < gj; d++) sr[d] <= sr[d-1];
        end
      end
      assign a_inj[gj] = sr[gj-1];
    end
  end

  always_comb begin
    for (int i = 0; i < ROWS; i++) begin
      for (int j = 0; j < COLS; j++) begin
        w_left[i][j] = (j == 0) ? w_inj[i] : w_pe[i][j-1];
        a_top[i][j]  = (i == 0) ? a_inj[j] : a_pe[i-1][j];
        prod[i][j]   = w_left[i][j] * a_top[i][j];
      end
    end
  end

  // The PE multiplies the operands arriving this step and latches them for its neighbours.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      w_pe <= '{default: '0};
      a_pe <= '{default: '0};
      acc  <= '{default: '0};
    end else if (step) begin
      for (int i = 0; i < ROWS; i++) begin
        for (int j = 0; j < COLS; j++) begin
          w_pe[i][j] <= w_left[i][j];
          a_pe[i][j] <= a_top[i][j];
          acc[i][j]  <= acc[i][j] + AW'(prod[i][j]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_row   <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (k_len == '0) begin
              state     <= S_DRAIN;
              out_valid <= 1'b1;
              out_row   <= '0;
              out_last  <= (ROWS == 1);
            end else begin
              state    <= S_LOAD;
              cnt      <= k_len;
              in_ready <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            cnt <= cnt - 1'b1;
            if (cnt == KW'(1)) begin
              in_ready <= 1'b0;
              if (FLUSH_N == 0) begin
                state     <= S_DRAIN;
                out_valid <= 1'b1;
                out_row   <= '0;
                out_last  <= (ROWS == 1);
              end else begin
                state <= S_FLUSH;
                cnt   <= KW'(FLUSH_N);
              end
            end
          end
        end
        S_FLUSH: begin
          cnt <= cnt - 1'b1;
          if (cnt == KW'(1)) begin
            state     <= S_DRAIN;
            out_valid <= 1'b1;
            out_row   <= '0;
            out_last  <= (ROWS == 1);
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (out_row == RW'(ROWS - 1)) begin
              state     <= S_IDLE;
              busy      <= 1'b0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_row   <= '0;
              done      <= 1'b1;
            end else begin
              out_row  <= out_row + RW'(1);
              out_last <= (out_row == RW'(ROWS - 2));
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    out_data = '0;
    for (int j = 0; j < COLS; j++) out_data[AW*j +: AW] = acc[out_row][j];
  end

endmodule

// File: tb/tb_systolic_tile.sv
// Directed bench for systolic_tile: two 2x2 instances (AW=32 and AW=16) share
// stimulus; hand-computed results are checked with immediate assertions.
module tb_systolic_tile;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] k_len;
  logic        in_valid;
  logic [15:0] in_w;
  logic [15:0] in_a;
  logic        out_ready;

  logic        busy32, in_ready32, out_valid32, out_last32, done32;
  logic [63:0] out_data32;
  logic [0:0]  out_row32;
  logic        busy16, in_ready16, out_valid16, out_last16, done16;
  logic [31:0] out_data16;
  logic [0:0]  out_row16;

  int vectors = 0;
  int miscompares = 0;
  int lat;

  always #5 clk = ~clk;

  systolic_tile #(.ROWS(2), .COLS(2), .DW(8), .AW(32), .KW(16)) dut32 (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(busy32),
    .in_valid(in_valid), .in_ready(in_ready32), .in_w(in_w), .in_a(in_a),
    .out_valid(out_valid32), .out_ready(out_ready), .out_data(out_data32),
    .out_row(out_row32), .out_last(out_last32), .done(done32));

  systolic_tile #(.ROWS(2), .COLS(2), .DW(8), .AW(16), .KW(16)) dut16 (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(busy16),
    .in_valid(in_valid), .in_ready(in_ready16), .in_w(in_w), .in_a(in_a),
    .out_valid(out_valid16), .out_ready(out_ready), .out_data(out_data16),
    .out_row(out_row16), .out_last(out_last16), .done(done16));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input logic [15:0] k);
    @(negedge clk);
    start = 1'b1;
    k_len = k;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offers one operand vector and holds it until the tile accepts it.
  task automatic send(input logic [15:0] w, input logic [15:0] a);
    int t = 0;
    in_w = w;
    in_a = a;
    in_valid = 1'b1;
    while (!in_ready32 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("in_ready_offer", in_ready32, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input logic [63:0] r0, input logic [63:0] r1,
                       input logic [31:0] h0, input logic [31:0] h1, input int stall);
    int t = 0;
    out_ready = 1'b0;
    while (!out_valid32 && t < 100) begin
      @(negedge clk);
      t++;
    end
    lat = t;
    chk("out_valid_rise", out_valid32, 1'b1);
    chk("in_ready_drain", in_ready32, 1'b0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("hold_valid", out_valid32, 1'b1);
      chk("hold_row", out_row32, 1'b0);
      chk("hold_data", out_data32, r0);
    end
    chk("row0_idx", out_row32, 1'b0);
    chk("row0_last", out_last32, 1'b0);
    chk("row0_data32", out_data32, r0);
    chk("row0_data16", out_data16, h0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("row1_idx", out_row32, 1'b1);
    chk("row1_last", out_last32, 1'b1);
    chk("row1_data32", out_data32, r1);
    chk("row1_data16", out_data16, h1);
    chk("done_early", done32, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("done_pulse", done32, 1'b1);
    chk("done16_pulse", done16, 1'b1);
    chk("busy_after", busy32, 1'b0);
    chk("valid_after", out_valid32, 1'b0);
    @(negedge clk);
    chk("done_one_cycle", done32, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0;
    in_w = '0; in_a = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy32, 1'b0);
    chk("rst_in_ready", in_ready32, 1'b0);
    chk("rst_out_valid", out_valid32, 1'b0);
    chk("rst_out_last", out_last32, 1'b0);
    chk("rst_done", done32, 1'b0);
    chk("rst_out_data", out_data32, 64'd0);
    chk("rst_out_row", out_row32, 1'b0);
    rst = 1'b0;

    // 1: basic 2x2 product, in_valid held; first out_valid two cycles after last beat
    start_job(16'd2);
    chk("load_busy", busy32, 1'b1);
    chk("load_in_ready", in_ready32, 1'b1);
    in_w = {8'd3, 8'd1}; in_a = {8'd7, 8'd5}; in_valid = 1'b1;
    @(negedge clk);
    in_w = {8'd4, 8'd2}; in_a = {8'd8, 8'd6};
    @(negedge clk);
    in_valid = 1'b0;
    chk("flush_in_ready", in_ready32, 1'b0);
    drain({32'd23, 32'd17}, {32'd53, 32'd39}, {16'd23, 16'd17}, {16'd53, 16'd39}, 0);
    chk("latency_s1", lat, 2);

    // 2: in_valid pattern 1,0,0,1 -> no step while idle, same results
    start_job(16'd2);
    send({8'd3, 8'd1}, {8'd7, 8'd5});
    @(negedge clk);
    chk("gap_in_ready", in_ready32, 1'b1);
    @(negedge clk);
    chk("gap_out_valid", out_valid32, 1'b0);
    send({8'd4, 8'd2}, {8'd8, 8'd6});
    chk("s2_flush_ready", in_ready32, 1'b0);
    drain({32'd23, 32'd17}, {32'd53, 32'd39}, {16'd23, 16'd17}, {16'd53, 16'd39}, 0);

    // 3: back-pressure on row 0 for three cycles
    start_job(16'd2);
    send({8'd3, 8'd1}, {8'd7, 8'd5});
    send({8'd4, 8'd2}, {8'd8, 8'd6});
    drain({32'd23, 32'd17}, {32'd53, 32'd39}, {16'd23, 16'd17}, {16'd53, 16'd39}, 3);

    // 4a: -1 * 2 wraps to all-ones-minus-one
    start_job(16'd1);
    send({8'h00, 8'hFF}, {8'h00, 8'h02});
    drain({32'd0, 32'hFFFF_FFFE}, 64'd0, {16'd0, 16'hFFFE}, 32'd0, 0);

    // 4b: (-128)*(-128) twice overflows a 16-bit accumulator
    start_job(16'd2);
    send({8'h00, 8'h80}, {8'h00, 8'h80});
    send({8'h00, 8'h80}, {8'h00, 8'h80});
    drain({32'd0, 32'h0000_8000}, 64'd0, {16'd0, 16'h8000}, 32'd0, 0);

    // 5: k_len=0 goes straight to DRAIN with zeros; start during DRAIN ignored
    start_job(16'd0);
    chk("k0_in_ready", in_ready32, 1'b0);
    chk("k0_out_valid", out_valid32, 1'b1);
    start = 1'b1;
    k_len = 16'd2;
    @(negedge clk);
    start = 1'b0;
    chk("k0_ign_busy", busy32, 1'b1);
    chk("k0_ign_valid", out_valid32, 1'b1);
    chk("k0_ign_ready", in_ready32, 1'b0);
    drain(64'd0, 64'd0, 32'd0, 32'd0, 0);
    chk("k0_idle_ready", in_ready32, 1'b0);

    // 6: reset mid-LOAD abandons the job, then a clean rerun of scenario 1
    start_job(16'd2);
    send({8'd9, 8'd9}, {8'd9, 8'd9});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", busy32, 1'b0);
    chk("midrst_valid", out_valid32, 1'b0);
    chk("midrst_ready", in_ready32, 1'b0);
    start_job(16'd2);
    in_w = {8'd3, 8'd1}; in_a = {8'd7, 8'd5}; in_valid = 1'b1;
    @(negedge clk);
    in_w = {8'd4, 8'd2}; in_a = {8'd8, 8'd6};
    @(negedge clk);
    in_valid = 1'b0;
    drain({32'd23, 32'd17}, {32'd53, 32'd39}, {16'd23, 16'd17}, {16'd53, 16'd39}, 0);
    chk("latency_s6", lat, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
